// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment capture block:
// segment codes, FSM states, frame bundle and defaults.
package sevenseg_pkg;

    localparam int SETTLE_DEF   = 2;
    localparam int STABLE_N_DEF = 3;
    localparam int TIMEOUT_DEF  = 4096;

    // abcdefg, a in bit 6, 1 = lit
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        WAIT_T = 2'd0,
        WAIT_U = 2'd1,
        CHECK  = 2'd2
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] tens;
        logic [3:0] units;
    } frame_t;

    function automatic logic [6:0] bcd_to_bin(
        input logic [3:0] t,
        input logic [3:0] u
    );
        return (7'(t) * 7'd10) + 7'(u);
    endfunction

endpackage

// File: rtl/sevenseg_capture_decode.sv
// Combinational segment-pattern to BCD digit decoder.
// A dark pattern is reported as blank, never as ok.
module seg7_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok,
    output logic       blank
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
            SEG_BLANK: begin
                ok    = 1'b0;
                blank = 1'b1;
            end
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures a multiplexed two-digit signed display, debounces
// whole frames and publishes the stable reading.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int SETTLE   = SETTLE_DEF,
    parameter int STABLE_N = STABLE_N_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       sign0,
    input  logic       dis1,
    input  logic       dis0,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       neg,
    output logic [6:0] mag,
    output logic       valid,
    output logic       err,
    output logic       stale
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(STABLE_N + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [9:0] raw;
    logic [9:0] sync1;
    logic [9:0] sync2;

    assign raw = {a, b, c, d, e, f, g, sign0, dis1, dis0};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    logic [6:0] seg_s;
    logic       sign_s;
    logic       tens_on;
    logic       units_on;

    assign seg_s    = ~sync2[9:3];
    assign sign_s   = ~sync2[2];
    assign tens_on  = ~sync2[1] & sync2[0];
    assign units_on = sync2[1] & ~sync2[0];

    // Strobe age counters; each saturates so it fires once per assertion
    logic [SW-1:0] t_age;
    logic [SW-1:0] u_age;
    logic          t_smp;
    logic          u_smp;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            t_age <= '0;
            u_age <= '0;
        end else begin
            if (!tens_on)
                t_age <= '0;
            else if (t_age != SW'(SETTLE))
                t_age <= t_age + 1'b1;
            if (!units_on)
                u_age <= '0;
            else if (u_age != SW'(SETTLE))
                u_age <= u_age + 1'b1;
        end
    end

    assign t_smp = tens_on && (t_age == SW'(SETTLE - 1));
    assign u_smp = units_on && (u_age == SW'(SETTLE - 1));

    logic [3:0] dig;
    logic       dig_ok;
    logic       dig_blank;

    seg7_decode u_dec (
        .seg   (seg_s),
        .digit (dig),
        .ok    (dig_ok),
        .blank (dig_blank)
    );

    logic good_t;
    logic good_u;
    logic bad;
    logic accepted;

    assign good_t   = t_smp & (dig_ok | dig_blank);
    assign good_u   = u_smp & dig_ok;
    assign bad      = (t_smp & ~dig_ok & ~dig_blank) | (u_smp & ~dig_ok);
    assign accepted = good_t | good_u;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT_T;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bad) begin
            state_nxt = WAIT_T;
        end else begin
            unique case (state)
                WAIT_T:  if (good_t) state_nxt = WAIT_U;
                WAIT_U:  if (good_u) state_nxt = CHECK;
                CHECK:   state_nxt = good_t ? WAIT_U : WAIT_T;
                default: state_nxt = WAIT_T;
            endcase
        end
    end

    logic load_t;
    logic load_u;
    logic do_check;

    always_comb begin
        load_t   = 1'b0;
        load_u   = 1'b0;
        do_check = 1'b0;
        if (!bad) begin
            unique case (state)
                WAIT_T: load_t = good_t;
                WAIT_U: begin
                    load_t = good_t;
                    load_u = good_u;
                end
                CHECK: begin
                    load_t   = good_t;
                    do_check = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic          cur_neg;
    logic [3:0]    cur_tens;
    logic [3:0]    cur_units;
    frame_t        cur_frame;
    frame_t        prev_frame;
    frame_t        pub_frame;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_nxt;
    logic          publish;

    // A lit minus on a zero reading is treated as plain zero
    always_comb begin
        cur_frame.tens  = cur_tens;
        cur_frame.units = cur_units;
        cur_frame.neg   = cur_neg & ((cur_tens != 4'd0) | (cur_units != 4'd0));
    end

    assign pub_frame = '{neg: neg, tens: tens, units: units};

    always_comb begin
        match_nxt = MW'(1);
        if (cur_frame == prev_frame) begin
            if (match_cnt == MW'(STABLE_N))
                match_nxt = match_cnt;
            else
                match_nxt = match_cnt + 1'b1;
        end
    end

    assign publish = do_check
                  && (match_nxt == MW'(STABLE_N))
                  && (cur_frame != pub_frame);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cur_neg    <= 1'b0;
            cur_tens   <= 4'd0;
            cur_units  <= 4'd0;
            prev_frame <= '0;
            match_cnt  <= '0;
            tens       <= 4'd0;
            units      <= 4'd0;
            neg        <= 1'b0;
            mag        <= 7'd0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            valid <= publish;
            err   <= bad;
            if (load_t) begin
                cur_tens <= dig;
                cur_neg  <= sign_s;
            end
            if (load_u)
                cur_units <= dig;
            if (bad) begin
                match_cnt <= '0;
            end else if (do_check) begin
                match_cnt  <= match_nxt;
                prev_frame <= cur_frame;
            end
            if (publish) begin
                tens  <= cur_frame.tens;
                units <= cur_frame.units;
                neg   <= cur_frame.neg;
                mag   <= bcd_to_bin(cur_frame.tens, cur_frame.units);
            end
        end
    end

    logic [IW-1:0] idle_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else begin
            if (accepted)
                idle_cnt <= '0;
            else if (idle_cnt != IW'(TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
            if (publish)
                stale <= 1'b0;
            else if (!accepted && idle_cnt == IW'(TIMEOUT - 1))
                stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed scoreboard bench for sevenseg_capture: expected
// publishes are queued by the stimulus and popped on valid.
module tb_sevenseg_capture;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1;
    logic       e = 1'b1, f = 1'b1, g = 1'b1;
    logic       sign0 = 1'b1;
    logic       dis1  = 1'b1;
    logic       dis0  = 1'b1;
    logic [3:0] tens, units;
    logic       neg;
    logic [6:0] mag;
    logic       valid, err, stale;

    sevenseg_capture dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .e      (e),
        .f      (f),
        .g      (g),
        .sign0  (sign0),
        .dis1   (dis1),
        .dis0   (dis0),
        .tens   (tens),
        .units  (units),
        .neg    (neg),
        .mag    (mag),
        .valid  (valid),
        .err    (err),
        .stale  (stale)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int t;
        int u;
        int n;
        int m;
    } exp_t;

    exp_t q[$];
    int   err_exp = 0;
    int   checks  = 0;
    int   errors  = 0;

    localparam logic [6:0] BLANK = 7'b0000000;
    localparam logic [6:0] BAD   = 7'b1000000;

    function automatic logic [6:0] pat(input int dg);
        case (dg)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int t, input int u, input int n, input int m);
        exp_t x;
        x.t = t;
        x.u = u;
        x.n = n;
        x.m = m;
        q.push_back(x);
    endtask

    task automatic drive(input logic [6:0] p, input logic s,
                         input logic d1, input logic d0, input int n);
        {a, b, c, d, e, f, g} = ~p;
        sign0 = ~s;
        dis1  = d1;
        dis0  = d0;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        drive(BLANK, 1'b0, 1'b1, 1'b1, n);
    endtask

    task automatic frame(input logic s, input logic [6:0] tp,
                         input logic [6:0] up);
        drive(tp, s, 1'b0, 1'b1, 4);
        idle(1);
        drive(up, 1'b0, 1'b1, 1'b0, 4);
        idle(2);
    endtask

    always @(negedge clk_in) begin
        if (valid) begin : mon_valid
            exp_t x;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got tens=%0d units=%0d neg=%0d, required no publish",
                         tens, units, neg);
            end else begin
                x = q.pop_front();
                chk("pub_tens", int'(tens), x.t);
                chk("pub_units", int'(units), x.u);
                chk("pub_neg", int'(neg), x.n);
                chk("pub_mag", int'(mag), x.m);
            end
        end
        if (err) begin
            checks++;
            if (err_exp == 0) begin
                errors++;
                $display("FAIL unexpected_err: got err=1, required err=0");
            end else begin
                err_exp--;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_tens", int'(tens), 0);
        chk("rst_units", int'(units), 0);
        chk("rst_neg", int'(neg), 0);
        chk("rst_mag", int'(mag), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_stale", int'(stale), 0);
        rst_n = 1'b1;
        idle(3);

        push_exp(1, 2, 1, 12);
        repeat (3) frame(1'b1, pat(1), pat(2));
        idle(4);
        chk("m12_neg_held", int'(neg), 1);

        push_exp(2, 7, 0, 27);
        repeat (10) frame(1'b0, pat(2), pat(7));
        idle(4);

        push_exp(0, 5, 0, 5);
        repeat (3) frame(1'b0, BLANK, pat(5));
        idle(4);
        chk("blank_tens", int'(tens), 0);

        frame(1'b0, pat(3), pat(4));
        err_exp++;
        frame(1'b0, pat(3), BAD);
        idle(4);
        chk("err_seen", err_exp, 0);
        chk("err_hold_units", int'(units), 5);
        chk("err_hold_mag", int'(mag), 5);
        repeat (2) frame(1'b0, pat(3), pat(4));
        idle(4);
        chk("err_two_frames_mag", int'(mag), 5);
        push_exp(3, 4, 0, 34);
        frame(1'b0, pat(3), pat(4));
        idle(4);
        chk("err_third_frame_pub", q.size(), 0);

        for (int i = 0; i < 8; i++) begin
            frame(1'b0, BLANK, pat(7));
            frame(1'b0, BLANK, pat(8));
        end
        idle(4);
        chk("alt_mag_held", int'(mag), 34);

        idle(3900);
        chk("stale_early", int'(stale), 0);
        idle(300);
        chk("stale_set", int'(stale), 1);
        frame(1'b0, BLANK, pat(3));
        chk("stale_until_valid", int'(stale), 1);
        push_exp(0, 3, 0, 3);
        repeat (2) frame(1'b0, BLANK, pat(3));
        idle(4);
        chk("stale_cleared", int'(stale), 0);

        frame(1'b0, pat(5), pat(6));
        drive(pat(5), 1'b0, 1'b0, 1'b1, 4);
        rst_n = 1'b0;
        @(negedge clk_in);
        chk("midrst_tens", int'(tens), 0);
        chk("midrst_units", int'(units), 0);
        chk("midrst_mag", int'(mag), 0);
        chk("midrst_neg", int'(neg), 0);
        chk("midrst_valid", int'(valid), 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        repeat (2) frame(1'b0, pat(5), pat(6));
        idle(4);
        chk("midrst_two_frames_mag", int'(mag), 0);
        push_exp(5, 6, 0, 56);
        frame(1'b0, pat(5), pat(6));
        idle(10);

        chk("pending_valid", q.size(), 0);
        chk("pending_err", err_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter SETTLE, default 2: consecutive synchronized cycles a digit strobe must be held before its segments are sampled.
REQ-002 Parameter STABLE_N, default 3: identical consecutive complete frames required before a result is published.
REQ-003 Parameter TIMEOUT, default 4096: cycles without any accepted digit sample before stale is asserted.
REQ-004 clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a,b,c,d,e,f,g  input  1 each  segment lines, active-low (0 = lit).
REQ-007 sign0  input  1  minus-sign LED, active-low, meaningful only while dis1 is enabled.
REQ-008 dis1, dis0  input  1 each  digit enables, active-low; dis1 = tens digit, dis0 = units digit.
REQ-009 tens, units  output  4 each  decoded BCD digits of the last published result.
REQ-010 neg  output  1  sign of the last published result (1 = negative).
REQ-011 mag  output  7  binary magnitude, tens*10+units.
REQ-012 valid  output  1  one-cycle pulse when a new result is published.
REQ-013 err  output  1  one-cycle pulse on an undecodable segment pattern.
REQ-014 stale  output  1  level; no accepted digit sample for TIMEOUT cycles.

Function
REQ-015 All 10 display inputs SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Tens strobe = dis1 low and dis0 high; units strobe = dis0 low and dis1 high; both low or both high SHALL be treated as no strobe.
REQ-017 Each strobe SHALL be sampled exactly once per assertion, on its SETTLE-th consecutive active cycle; a strobe shorter than SETTLE is ignored.
REQ-018 Decoding uses abcdefg (active-high after inversion): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-019 An all-dark tens digit SHALL decode as 0 (leading blank); an all-dark units digit SHALL be an error.
REQ-020 FSM states: WAIT_T (expect tens), WAIT_U (expect units), CHECK (compare frame); reset state WAIT_T.
REQ-021 WAIT_T: a tens sample stores tens and neg, then goes to WAIT_U; a units sample is discarded and the state stays WAIT_T.
REQ-022 WAIT_U: a units sample stores units, then goes to CHECK; a tens sample replaces the stored tens and neg and stays in WAIT_U.
REQ-023 CHECK (one cycle): if the frame equals the previous frame, increment match_cnt (saturating at STABLE_N); otherwise set match_cnt=1; then return to WAIT_T.
REQ-024 Publish when match_cnt reaches STABLE_N and the frame differs from the published outputs: update outputs and pulse valid the same cycle; identical repeats SHALL NOT re-pulse valid.
REQ-025 neg=1 with magnitude 0 SHALL be normalized to neg=0 before comparison.
REQ-026 An undecodable pattern SHALL pulse err, clear match_cnt, discard the partial frame, and force WAIT_T; published outputs are held.
REQ-027 The idle counter SHALL reset on every accepted sample; stale SHALL assert when the counter reaches TIMEOUT and clear on the next valid pulse.
REQ-028 Published outputs SHALL change only on a valid pulse.

Reset
REQ-029 While rst_n is low: tens=0, units=0, neg=0, mag=0, valid=0, err=0, stale=0, match_cnt=0, synchronizers=all-inactive (1), state=WAIT_T.
REQ-030 Reset asserted mid-frame SHALL discard all partial data; the first publish after release requires STABLE_N fresh frames.

Structure
REQ-031 The segment code table, state encodings and default parameter values SHALL live in shared package sevenseg_pkg.
REQ-032 Pattern-to-digit decoding SHALL be a combinational sub-module seg7_decode (7-bit in, 4-bit digit, ok flag, blank flag).

Verification
REQ-033 Scan -12 (sign0 lit, tens=1, units=2) for 3 frames -> one valid pulse, neg=1, tens=1, units=2, mag=12.
REQ-034 Scan 27 for 10 frames -> exactly one valid pulse; scan 5 with a blank tens digit for 3 frames -> valid, tens=0, mag=5.
REQ-035 Units pattern 1000000 injected mid-scan -> err pulse, outputs held, 3 further clean frames needed for the next publish.
REQ-036 Alternate 7 and 8 every frame -> no valid pulse ever.
REQ-037 Stop scanning (both enables high) for 4096 cycles -> stale=1; resume scanning 3 -> stale clears on the valid pulse.
REQ-038 Assert rst_n low after the tens sample of frame 2 -> all outputs 0; after release 3 full frames are needed to publish.
